// File: rtl/dram_pkg.sv
// Shared helpers for the banked multi-port data memory: index widths,
// per-port slice offsets and the elaboration-time geometry check.
package dram_pkg;

    function automatic int bank_bits(input int nbanks);
        return (nbanks <= 1) ? 0 : $clog2(nbanks);
    endfunction

    // Width of an index into n items; never zero so vectors stay legal.
    function automatic int idx_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int slice_lo(input int p, input int w);
        return p * w;
    endfunction

    function automatic bit depth_ok(input int depth, input int nbanks);
        return (nbanks > 0) && (depth % nbanks == 0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one bank: grants the first requester at or after
// the pointer, then moves the pointer just past the winner.
module rr_arbiter
    import dram_pkg::*;
#(
    parameter int NPORTS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NPORTS-1:0] req,
    output logic [NPORTS-1:0] gnt
);

    localparam int PW = idx_bits(NPORTS);

    logic [PW-1:0] ptr;
    logic [PW-1:0] cand;
    logic [PW-1:0] gidx;
    logic          found;

    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input int b);
        int s;
        s = int'(a) + b;
        if (s >= NPORTS) s = s - NPORTS;
        return PW'(s);
    endfunction

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        gidx  = '0;
        cand  = '0;
        for (int i = 0; i < NPORTS; i++) begin
            cand = wrap_add(ptr, i);
            if (!found && req[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
        if (found) gnt[gidx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= wrap_add(gidx, 1);
        end
    end

endmodule

// File: rtl/dram_mp_arb.sv
// Banked, word-interleaved shared data memory serving NPORTS core ports with
// per-bank round-robin arbitration and a registered, rvalid-qualified read return.
module dram_mp_arb
    import dram_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 1024,
    parameter int NPORTS = 4,
    parameter int NBANKS = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS-1:0]        gnt,
    output logic [NPORTS-1:0]        rvalid,
    output logic [NPORTS*DATA_W-1:0] rdata
);

    localparam int BANK_BITS = bank_bits(NBANKS);
    localparam int BW        = idx_bits(NBANKS);
    localparam int ROWS      = DEPTH / NBANKS;
    localparam int ROW_W     = idx_bits(ROWS);

    if (!depth_ok(DEPTH, NBANKS)) begin : g_bad_geometry
        $error("dram_mp_arb: DEPTH must be a multiple of NBANKS");
    end

    logic [BW-1:0]     port_bank [NPORTS];
    logic [ROW_W-1:0]  port_row  [NPORTS];
    logic [NPORTS-1:0] port_oob;
    logic [ADDR_W-1:0] a_cur;

    // Address decode: low bits pick the bank, the rest pick the row.
    always_comb begin
        a_cur     = '0;
        port_oob  = '0;
        port_bank = '{default: '0};
        port_row  = '{default: '0};
        for (int p = 0; p < NPORTS; p++) begin
            a_cur        = addr[slice_lo(p, ADDR_W) +: ADDR_W];
            port_oob[p]  = ({1'b0, a_cur} >= (ADDR_W+1)'(DEPTH));
            port_bank[p] = BW'(a_cur & ADDR_W'(NBANKS - 1));
            port_row[p]  = ROW_W'(a_cur >> BANK_BITS);
        end
    end

    logic [NPORTS-1:0] bank_gnt [NBANKS];
    logic [DATA_W-1:0] bank_rd  [NBANKS];

    for (genvar b = 0; b < NBANKS; b++) begin : g_bank
        logic [NPORTS-1:0] breq;
        logic              sel_we;
        logic              sel_oob;
        logic [ROW_W-1:0]  sel_row;
        logic [DATA_W-1:0] sel_wdata;
        logic [DATA_W-1:0] mem [ROWS];

        always_comb begin
            breq = '0;
            for (int p = 0; p < NPORTS; p++) begin
                breq[p] = req[p] && (port_bank[p] == BW'(b));
            end
        end

        rr_arbiter #(.NPORTS(NPORTS)) u_arb (
            .clk   (clk),
            .rst_n (rst_n),
            .req   (breq),
            .gnt   (bank_gnt[b])
        );

        // The one-hot grant selects which port's access reaches this bank.
        always_comb begin
            sel_we    = 1'b0;
            sel_oob   = 1'b0;
            sel_row   = '0;
            sel_wdata = '0;
            for (int p = 0; p < NPORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    sel_we    = we[p];
                    sel_oob   = port_oob[p];
                    sel_row   = port_row[p];
                    sel_wdata = wdata[slice_lo(p, DATA_W) +: DATA_W];
                end
            end
        end

        always_ff @(posedge clk) begin
            if ((|bank_gnt[b]) && sel_we && !sel_oob) begin
                mem[sel_row] <= sel_wdata;
            end
        end

        assign bank_rd[b] = mem[sel_row];
    end

    always_comb begin
        gnt = '0;
        for (int b = 0; b < NBANKS; b++) begin
            gnt = gnt | bank_gnt[b];
        end
    end

    // Read return stage: data and valid one cycle after the grant edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= '0;
            rdata  <= '0;
        end else begin
            for (int p = 0; p < NPORTS; p++) begin
                rvalid[p] <= gnt[p] && !we[p];
                if (gnt[p] && !we[p]) begin
                    rdata[slice_lo(p, DATA_W) +: DATA_W] <= port_oob[p] ? '0 : bank_rd[port_bank[p]];
                end
            end
        end
    end

endmodule

// File: tb/tb_dram_mp_arb.sv
// Directed bench for dram_mp_arb with a read-return scoreboard and a memory model.
module tb_dram_mp_arb;

    localparam int DW    = 16;
    localparam int AW    = 16;
    localparam int NP    = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 1024;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NP-1:0]       req;
    logic [NP-1:0]       we;
    logic [NP*AW-1:0]    addr;
    logic [NP*DW-1:0]    wdata;
    logic [NP-1:0]       gnt;
    logic [NP-1:0]       rvalid;
    logic [NP*DW-1:0]    rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    dram_mp_arb #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH),
        .NPORTS (NP),
        .NBANKS (NB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[p]           = r;
        we[p]            = w;
        addr[p*AW +: AW] = a;
        wdata[p*DW +: DW] = d;
    endtask

    task automatic drop_all();
        for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    // One clock: check grants mid-cycle, update the model / push expected reads,
    // then check the read return just after the edge.
    task automatic tick(input string tag, input logic [NP-1:0] exp_gnt);
        logic [NP-1:0] pend;
        logic [AW-1:0] a;
        logic [DW-1:0] e;
        @(negedge clk);
        check({tag, "_gnt"}, 64'(gnt), 64'(exp_gnt));
        pend = '0;
        for (int p = 0; p < NP; p++) begin
            if (gnt[p]) begin
                a = addr[p*AW +: AW];
                if (we[p]) begin
                    if (a < AW'(DEPTH)) model[a[9:0]] = wdata[p*DW +: DW];
                end else begin
                    pend[p] = 1'b1;
                    exp_q.push_back((a < AW'(DEPTH)) ? model[a[9:0]] : '0);
                end
            end
        end
        @(posedge clk);
        #1;
        check({tag, "_rvalid"}, 64'(rvalid), 64'(pend));
        for (int p = 0; p < NP; p++) begin
            if (pend[p]) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check($sformatf("%s_rdata%0d", tag, p), 64'(rdata[p*DW +: DW]), 64'(e));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        we    = '0;
        addr  = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_rdata",  64'(rdata),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_gnt", 64'(gnt), 64'(0));

        // Write then read-after-write on the same address (bank 2).
        drive(0, 1'b1, 1'b1, 16'd10, 16'h0055);
        tick("t1_wr", 4'b0001);
        drop_all();
        drive(1, 1'b1, 1'b0, 16'd10, 16'h0000);
        tick("t1_rd", 4'b0010);
        check("t1_data", 64'(rdata[31:16]), 64'(16'h0055));
        drop_all();

        // Four writers collide on bank 0; each drops req once granted.
        for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, 16'd4, 16'(16'hA000 + p));
        for (int i = 0; i < NP; i++) begin
            tick($sformatf("t2_c%0d", i), 4'(1 << i));
            drive(i, 1'b0, 1'b0, '0, '0);
        end
        drive(0, 1'b1, 1'b0, 16'd4, 16'h0000);
        tick("t2_rd", 4'b0001);
        check("t2_last_writer", 64'(rdata[15:0]), 64'(16'hA003));
        drop_all();

        // Four distinct banks in parallel: write then read addrs 0..3.
        for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b1, 16'(p), 16'(16'h1110 * (p + 1)));
        tick("t3_wr", 4'b1111);
        for (int p = 0; p < NP; p++) drive(p, 1'b1, 1'b0, 16'(p), 16'h0000);
        tick("t3_rd", 4'b1111);
        check("t3_rdata3", 64'(rdata[63:48]), 64'(16'h4440));
        drop_all();

        // Out-of-range write is dropped; out-of-range read returns zero.
        drive(2, 1'b1, 1'b1, 16'd1024, 16'hBEEF);
        tick("t4_wr", 4'b0100);
        drive(2, 1'b1, 1'b0, 16'd1024, 16'h0000);
        tick("t4_rd", 4'b0100);
        check("t4_oob_data", 64'(rdata[47:32]), 64'(0));
        drive(2, 1'b1, 1'b0, 16'd0, 16'h0000);
        tick("t4_addr0", 4'b0100);
        check("t4_addr0_data", 64'(rdata[47:32]), 64'(16'h1110));
        drop_all();

        // Bank 2 pointer sits at 3 after the parallel read, so port 3 wins first.
        drive(1, 1'b1, 1'b0, 16'd2,  16'h0000);
        drive(3, 1'b1, 1'b0, 16'd10, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            tick($sformatf("t5_c%0d", i), (i % 2 == 0) ? 4'b1000 : 4'b0010);
        end
        drop_all();

        // Read granted, then reset arrives before the return edge.
        drive(1, 1'b1, 1'b0, 16'd4, 16'h0000);
        @(negedge clk);
        check("t6_gnt", 64'(gnt), 64'(4'b0010));
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("t6_rvalid", 64'(rvalid), 64'(0));
        check("t6_rdata",  64'(rdata),  64'(0));
        #2 rst_n = 1'b1;
        drop_all();
        // Without a pointer reset bank 0 would favour port 3 here.
        drive(1, 1'b1, 1'b0, 16'd4, 16'h0000);
        drive(3, 1'b1, 1'b0, 16'd0, 16'h0000);
        tick("t6_post", 4'b0010);
        check("t6_post_data", 64'(rdata[31:16]), 64'(16'hA003));
        drop_all();
        @(posedge clk);
        #1;
        check("t6_rvalid_pulse", 64'(rvalid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
